// File: rtl/qsec_countdown_if.sv
// Bus between the game controller and the quarter-second countdown timer.
// Command semantics (no valid/ready pair): ld is a single-cycle command
// qualified only by itself, always accepted at the edge where it is high;
// qsec is a one-cycle strobe; run is a level. All slave outputs are registered
// state or decoded from registered state only.
interface qsec_countdown_if #(
   parameter int SEC_W = 4
);
   logic             qsec;
   logic             ld;
   logic [SEC_W-1:0] sec_in;
   logic             run;
   logic [SEC_W-1:0] time_bits;
   logic             busy;
   logic             done;
   logic             expired;
   logic             flash;
   logic [1:0]       state_dbg;

   modport master (
      output qsec, ld, sec_in, run,
      input  time_bits, busy, done, expired, flash, state_dbg
   );

   modport slave (
      input  qsec, ld, sec_in, run,
      output time_bits, busy, done, expired, flash, state_dbg
   );
endinterface

// File: rtl/qsec_countdown.sv
// Loadable countdown timer: holds a whole-second budget as a count of
// quarter ticks, decrements on qsec while run is high, pulses done on reaching
// zero and then blinks flash until the next load or reset.
module qsec_countdown #(
   parameter int SEC_W = 4,
   parameter int QW    = 2
) (
   input  logic                    clk,
   input  logic                    Rn,
   qsec_countdown_if.slave         bus
);

   localparam int CW = SEC_W + QW;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_EXPIRED = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            flash_q, flash_d;

   // Next-state logic: load beats counting; reset is applied in the register.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      flash_d = flash_q;
      if (bus.ld) begin
         cnt_d   = {bus.sec_in, {QW{1'b0}}};
         flash_d = 1'b0;
         state_d = (bus.sec_in != '0) ? S_ARMED : S_IDLE;
      end else begin
         case (state_q)
            S_ARMED: begin
               // A qsec seen while paused is simply dropped.
               if (bus.qsec && bus.run) begin
                  cnt_d = cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) begin
                     state_d = S_EXPIRED;
                     done_d  = 1'b1;
                  end
               end
            end
            S_EXPIRED: begin
               // Count is pinned at zero so it can never wrap.
               cnt_d = '0;
               if (bus.qsec) begin
                  flash_d = ~flash_q;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!Rn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         flash_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         flash_q <= flash_d;
      end
   end

   // Remaining seconds rounded up: any leftover quarter counts as a second.
   assign bus.time_bits = cnt_q[CW-1:QW] + SEC_W'(|cnt_q[QW-1:0]);
   assign bus.busy      = (state_q == S_ARMED);
   assign bus.expired   = (state_q == S_EXPIRED);
   assign bus.done      = done_q;
   assign bus.flash     = flash_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_qsec_countdown.sv
// Bench for qsec_countdown: directed scenarios with literal expectations,
// plus a seconds/quarters model compared against the outputs every cycle.
module tb_qsec_countdown;

   logic clk;
   logic Rn;
   logic r_run;

   qsec_countdown_if #(.SEC_W(4)) bus ();

   qsec_countdown #(.SEC_W(4), .QW(2)) dut (
      .clk (clk),
      .Rn  (Rn),
      .bus (bus)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: remaining quarter ticks as a plain integer plus a mode word.
   int  m_rem;
   int  m_mode;   // 0 idle, 1 counting, 2 expired
   bit  m_done;
   bit  m_flash;

   initial begin
      m_rem = 0; m_mode = 0; m_done = 0; m_flash = 0;
   end

   always @(posedge clk) begin
      if (!Rn) begin
         m_rem = 0; m_mode = 0; m_done = 0; m_flash = 0;
      end else begin
         m_done = 0;
         if (bus.ld) begin
            m_rem   = 4 * int'(bus.sec_in);
            m_flash = 0;
            m_mode  = (bus.sec_in == 0) ? 0 : 1;
         end else if (m_mode == 1 && bus.qsec && bus.run) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_mode = 2;
               m_done = 1;
            end
         end else if (m_mode == 2 && bus.qsec) begin
            m_flash = !m_flash;
         end
      end
   end

   // Compare process, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_time_bits", int'(bus.time_bits), (m_rem + 3) / 4);
         check("model_busy",      int'(bus.busy),      int'(m_mode == 1));
         check("model_expired",   int'(bus.expired),   int'(m_mode == 2));
         check("model_done",      int'(bus.done),      int'(m_done));
         check("model_flash",     int'(bus.flash),     int'(m_flash));
      end
   end

   // One clock: drive inputs, then wait until the following negedge.
   task automatic cyc(input logic rn, input logic ld, input logic [3:0] sec,
                      input logic qs);
      Rn         = rn;
      bus.ld     = ld;
      bus.sec_in = sec;
      bus.qsec   = qs;
      bus.run    = r_run;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic load(input logic [3:0] sec);
      cyc(1'b1, 1'b1, sec, 1'b0);
   endtask

   // qsec pulse; outputs after it are valid when this returns, gap follows later
   task automatic qpulse();
      cyc(1'b1, 1'b0, 4'd0, 1'b1);
   endtask

   int seq_exp[8];

   initial begin
      r_run      = 1'b1;
      Rn         = 1'b0;
      bus.ld     = 1'b0;
      bus.sec_in = '0;
      bus.qsec   = 1'b0;
      bus.run    = 1'b1;

      // Reset beats a simultaneous load.
      cyc(1'b0, 1'b1, 4'd5, 1'b0);
      cmp_en = 1'b1;
      check("rst_time_bits", int'(bus.time_bits), 0);
      check("rst_busy",      int'(bus.busy),      0);
      check("rst_done",      int'(bus.done),      0);
      check("rst_expired",   int'(bus.expired),   0);
      check("rst_flash",     int'(bus.flash),     0);
      idle(2);

      // Full countdown from 2 seconds.
      seq_exp = '{2, 2, 2, 1, 1, 1, 1, 0};
      r_run = 1'b1;
      load(4'd2);
      check("load2_time_bits", int'(bus.time_bits), 2);
      check("load2_busy",      int'(bus.busy),      1);
      check("load2_done",      int'(bus.done),      0);
      idle(9);
      for (int k = 0; k < 8; k++) begin
         qpulse();
         check("cd_time_bits", int'(bus.time_bits), seq_exp[k]);
         check("cd_done", int'(bus.done), (k == 7) ? 1 : 0);
         if (k < 7) idle(9);
      end
      check("cd_expired", int'(bus.expired), 1);
      check("cd_busy",    int'(bus.busy),    0);
      idle(1);
      check("cd_done_drop",    int'(bus.done),    0);
      check("cd_expired_hold", int'(bus.expired), 1);

      // Pause: qsec while run is low is lost.
      load(4'd1);
      qpulse(); idle(3);
      qpulse(); idle(3);
      check("pause_pre_time", int'(bus.time_bits), 1);
      r_run = 1'b0;
      for (int k = 0; k < 3; k++) begin qpulse(); idle(3); end
      check("pause_time", int'(bus.time_bits), 1);
      check("pause_busy", int'(bus.busy),      1);
      r_run = 1'b1;
      qpulse(); idle(3);
      check("resume_done_early", int'(bus.done), 0);
      qpulse();
      check("resume_done", int'(bus.done),    1);
      check("resume_exp",  int'(bus.expired), 1);
      idle(3);

      // Expired: flash toggles, count never wraps, no further done.
      for (int k = 0; k < 4; k++) begin
         qpulse();
         check("exp_flash", int'(bus.flash), (k % 2 == 0) ? 1 : 0);
         check("exp_time",  int'(bus.time_bits), 0);
         check("exp_done",  int'(bus.done), 0);
         idle(3);
      end
      // flash toggles regardless of run
      r_run = 1'b0;
      qpulse();
      check("exp_flash_norun", int'(bus.flash), 1);
      r_run = 1'b1;
      idle(2);

      // Reload from EXPIRED with flash high.
      load(4'd15);
      check("reload_time",    int'(bus.time_bits), 15);
      check("reload_busy",    int'(bus.busy),      1);
      check("reload_expired", int'(bus.expired),   0);
      check("reload_flash",   int'(bus.flash),     0);
      idle(2);

      // Load beats a simultaneous qsec (cnt=5 at that point).
      load(4'd2);
      for (int k = 0; k < 3; k++) begin qpulse(); idle(2); end
      check("prec_pre_time", int'(bus.time_bits), 2);
      cyc(1'b1, 1'b1, 4'd3, 1'b1);
      check("prec_time", int'(bus.time_bits), 3);
      check("prec_busy", int'(bus.busy),      1);
      for (int k = 0; k < 3; k++) begin qpulse(); idle(2); end
      // 12 - 3 = 9 quarters left, still rounds up to 3
      check("prec_no_dec", int'(bus.time_bits), 3);

      // Zero load returns to idle; idle ignores qsec.
      load(4'd0);
      check("zero_busy",    int'(bus.busy),      0);
      check("zero_done",    int'(bus.done),      0);
      check("zero_expired", int'(bus.expired),   0);
      check("zero_time",    int'(bus.time_bits), 0);
      qpulse(); qpulse();
      check("idle_hold_time", int'(bus.time_bits), 0);
      check("idle_hold_busy", int'(bus.busy),      0);

      // Mid-countdown reset clears everything.
      load(4'd7);
      qpulse();
      cyc(1'b0, 1'b0, 4'd0, 1'b0);
      check("midrst_time", int'(bus.time_bits), 0);
      check("midrst_busy", int'(bus.busy),      0);
      idle(2);

      // Mixed stimulus, checked by the model only.
      for (int i = 0; i < 400; i++) begin
         r_run = ($urandom_range(0, 7) != 0);
         cyc(($urandom_range(0, 60) != 0),
             ($urandom_range(0, 19) == 0),
             4'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0));
      end

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
